// File: rtl/window_stats_accumulator.sv
// Windowed sum/max/min/count accumulator for the 17-bit transform output stream.
// Closes a window on WINDOW samples or on flush, then holds the result until it is transferred downstream.
module window_stats_accumulator #(
    parameter int unsigned DATA_W = 17,
    parameter int unsigned WINDOW = 8,
    parameter int unsigned SUM_W  = 20,
    parameter int unsigned CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [SUM_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

    typedef enum logic {ACCUM, FULL} state_t;

    state_t            state;
    logic [SUM_W-1:0]  acc_sum;
    logic [DATA_W-1:0] acc_max;
    logic [DATA_W-1:0] acc_min;
    logic [CNT_W-1:0]  acc_cnt;
    logic              acc_ovf;

    logic              accept;
    logic              transfer;
    logic              close;
    logic [SUM_W:0]    sum_ext;
    logic [SUM_W-1:0]  nxt_sum;
    logic [DATA_W-1:0] nxt_max;
    logic [DATA_W-1:0] nxt_min;
    logic [CNT_W-1:0]  nxt_cnt;
    logic              nxt_ovf;

    // A held result frees the input only when it is being drained this cycle.
    assign in_ready = (state == ACCUM) ? 1'b1 : out_ready;
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;
    assign sum_ext  = {1'b0, acc_sum} + (SUM_W + 1)'(in_data);

    // Working window including any sample accepted this cycle.
    always_comb begin
        nxt_sum = acc_sum;
        nxt_max = acc_max;
        nxt_min = acc_min;
        nxt_cnt = acc_cnt;
        nxt_ovf = acc_ovf;
        if (accept) begin
            nxt_sum = sum_ext[SUM_W-1:0];
            nxt_ovf = acc_ovf | sum_ext[SUM_W];
            nxt_cnt = acc_cnt + CNT_W'(1);
            if (in_data > acc_max) nxt_max = in_data;
            if (in_data < acc_min) nxt_min = in_data;
        end
    end

    assign close = (accept && (acc_cnt == LAST_CNT)) || (flush && (nxt_cnt != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ACCUM;
            out_sum      <= '0;
            out_max      <= '0;
            out_min      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
            out_valid    <= 1'b0;
            acc_sum      <= '0;
            acc_max      <= '0;
            acc_min      <= '1;
            acc_cnt      <= '0;
            acc_ovf      <= 1'b0;
        end else if (close) begin
            state        <= FULL;
            out_sum      <= nxt_sum;
            out_max      <= nxt_max;
            out_min      <= nxt_min;
            out_count    <= nxt_cnt;
            out_overflow <= nxt_ovf;
            out_valid    <= 1'b1;
            acc_sum      <= '0;
            acc_max      <= '0;
            acc_min      <= '1;
            acc_cnt      <= '0;
            acc_ovf      <= 1'b0;
        end else begin
            if (accept) begin
                acc_sum <= nxt_sum;
                acc_max <= nxt_max;
                acc_min <= nxt_min;
                acc_cnt <= nxt_cnt;
                acc_ovf <= nxt_ovf;
            end
            if (transfer) begin
                out_valid <= 1'b0;
                state     <= ACCUM;
            end
        end
    end

endmodule

// File: tb/tb_window_stats_accumulator.sv
// Directed bench for window_stats_accumulator: default build plus an SUM_W=18 build for overflow.
module tb_window_stats_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [16:0] in_data;
    logic        in_valid, flush, out_ready;
    logic        in_ready, out_valid, out_overflow;
    logic [19:0] out_sum;
    logic [16:0] out_max, out_min;
    logic [3:0]  out_count;

    logic [16:0] b_in_data;
    logic        b_in_valid, b_flush, b_out_ready;
    logic        b_in_ready, b_out_valid, b_out_overflow;
    logic [17:0] b_out_sum;
    logic [16:0] b_out_max, b_out_min;
    logic [3:0]  b_out_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    window_stats_accumulator u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .out_sum(out_sum), .out_max(out_max), .out_min(out_min),
        .out_count(out_count), .out_overflow(out_overflow), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    window_stats_accumulator #(.SUM_W(18)) u_dut18 (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .flush(b_flush), .out_sum(b_out_sum), .out_max(b_out_max), .out_min(b_out_min),
        .out_count(b_out_count), .out_overflow(b_out_overflow), .out_valid(b_out_valid),
        .out_ready(b_out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        b_in_data = '0; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_min", 32'(out_min), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        #9 rst_n = 1'b1;
        tick();

        // Samples 1..8 with out_ready=1.
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 17'(i);
            tick();
            if (i == 7) check("t1_no_early_valid", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_sum", 32'(out_sum), 32'd36);
        check("t1_max", 32'(out_max), 32'd8);
        check("t1_min", 32'(out_min), 32'd1);
        check("t1_count", 32'(out_count), 32'd8);
        check("t1_ovf", 32'(out_overflow), 32'd0);
        tick();
        check("t1_drained", 32'(out_valid), 32'd0);

        // Same window, downstream stalled for 5 cycles.
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 17'(i);
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("t2_hold_valid", 32'(out_valid), 32'd1);
            check("t2_hold_sum", 32'(out_sum), 32'd36);
            check("t2_hold_count", 32'(out_count), 32'd8);
            check("t2_in_ready_low", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1; in_valid = 1'b1; in_data = 17'd100;
        #1 check("t2_in_ready_follows", 32'(in_ready), 32'd1);
        tick();
        check("t2_transfer", 32'(out_valid), 32'd0);
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t2_flush_valid", 32'(out_valid), 32'd1);
        check("t2_new_sum", 32'(out_sum), 32'd100);
        check("t2_new_count", 32'(out_count), 32'd1);
        check("t2_new_max", 32'(out_max), 32'd100);
        check("t2_new_min", 32'(out_min), 32'd100);
        tick();
        check("t2_drained", 32'(out_valid), 32'd0);

        // Three full-scale samples, flush with the third.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 17'h1FFFF; flush = (i == 2);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0;
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_sum", 32'(out_sum), 32'h5FFFD);
        check("t3_count", 32'(out_count), 32'd3);
        check("t3_max", 32'(out_max), 32'h1FFFF);
        check("t3_min", 32'(out_min), 32'h1FFFF);
        tick();

        // Flush of an empty window is ignored.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_no_valid", 32'(out_valid), 32'd0);
        tick();
        check("t4_still_no_valid", 32'(out_valid), 32'd0);
        check("t4_in_ready", 32'(in_ready), 32'd1);
        check("t4_sum_kept", 32'(out_sum), 32'h5FFFD);

        // SUM_W=18 build: carry detection.
        b_in_valid = 1'b1; b_in_data = 17'h1FFFF;
        tick();
        b_flush = 1'b1;
        tick();
        check("t5a_valid", 32'(b_out_valid), 32'd1);
        check("t5a_sum", 32'(b_out_sum), 32'h3FFFE);
        check("t5a_ovf", 32'(b_out_overflow), 32'd0);
        check("t5a_count", 32'(b_out_count), 32'd2);
        b_in_data = 17'd1;
        tick();
        check("t5b_valid_stays", 32'(b_out_valid), 32'd1);
        check("t5b_sum", 32'(b_out_sum), 32'd1);
        check("t5b_ovf", 32'(b_out_overflow), 32'd0);
        check("t5b_count", 32'(b_out_count), 32'd1);
        b_flush = 1'b0; b_in_data = 17'h1FFFF;
        tick();
        check("t5c_transfer", 32'(b_out_valid), 32'd0);
        tick();
        b_in_data = 17'd2; b_flush = 1'b1;
        tick();
        b_in_valid = 1'b0; b_flush = 1'b0;
        check("t5c_valid", 32'(b_out_valid), 32'd1);
        check("t5c_sum", 32'(b_out_sum), 32'd0);
        check("t5c_ovf", 32'(b_out_overflow), 32'd1);
        check("t5c_count", 32'(b_out_count), 32'd3);
        check("t5c_max", 32'(b_out_max), 32'h1FFFF);
        check("t5c_min", 32'(b_out_min), 32'd2);
        tick();

        // Asynchronous reset in the middle of a window.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 17'd7;
            tick();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_sum", 32'(out_sum), 32'd0);
        check("t6_rst_max", 32'(out_max), 32'd0);
        check("t6_rst_count", 32'(out_count), 32'd0);
        check("t6_rst_b_ovf", 32'(b_out_overflow), 32'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 17'd2;
            tick();
        end
        in_valid = 1'b0;
        check("t6_valid", 32'(out_valid), 32'd1);
        check("t6_sum", 32'(out_sum), 32'd16);
        check("t6_count", 32'(out_count), 32'd8);
        check("t6_min", 32'(out_min), 32'd2);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
